axi_r_id_restore: RTL and testbench
===================================

Name: axi_r_id_restore

Overview:
- Response-side companion to the row/col ID allocator. Sits between the downstream slave R channel, which carries the compact {row,col} unique ID, and the upstream master R channel.
- Restores the original ARID on every beat through the allocator's combinational tag lookup.
- Pulses the allocator's free interface on each burst's final beat.
- Registers all master-side outputs through a 2-entry skid buffer, giving full throughput and 1-cycle latency.

Parameters:
- ID_WIDTH, 4, width of the original AXI ID
- NUM_ROWS, 4, allocator row count
- NUM_COLS, 4, allocator column count
- DATA_WIDTH, 32, RDATA width
- UID_W, $clog2(NUM_ROWS)+$clog2(NUM_COLS), unique-ID width (derived localparam, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_rvalid  in  1  slave-side beat valid
- s_rready  out  1  slave-side ready
- s_rid  in  UID_W  unique ID {row,col}
- s_rdata  in  DATA_WIDTH  read data
- s_rresp  in  2  response code
- s_rlast  in  1  last beat of burst
- m_rvalid  out  1  master-side valid
- m_rready  in  1  master-side ready
- m_rid  out  ID_WIDTH  restored original ID
- m_rdata  out  DATA_WIDTH  read data
- m_rresp  out  2  response code
- m_rlast  out  1  last beat
- free_req  out  1  free pulse to allocator
- free_unique_id  out  UID_W  slot to free / look up
- restored_id  in  ID_WIDTH  allocator combinational lookup result
- free_ack  in  1  allocator acknowledge, one cycle after free_req
- err_interleave  out  1  sticky: slave interleaved bursts
- err_ack  out  1  sticky: free_ack missing or unexpected

Behaviour:
- One clock (clk). Synchronous active-high reset (rst).
- Reset values:
  - m_rvalid, free_req, err_interleave, err_ack = 0.
  - m_rid, m_rdata, m_rresp, m_rlast = 0.
  - Both skid entries empty; FSM = IDLE; ack_pending = 0.
  - s_rready = 1 in the first cycle after reset.
- Lookup: free_unique_id = s_rid, combinational at all times. restored_id is sampled only on an s-side handshake (s_rvalid & s_rready).
- Datapath: each accepted beat {restored_id, s_rdata, s_rresp, s_rlast} enters the 2-entry skid buffer.
  - Latency: the beat appears on m_* the cycle after acceptance when the buffer was empty.
  - s_rready = entry-1 not occupied. This is a registered signal; it never depends combinationally on m_rready.
  - Sustains 1 beat/cycle when m_rready is held at 1.
  - When m_rready=0, the output is held stable while m_rvalid=1 (AXI rule). At most 2 beats are buffered, then s_rready drops.
- Free:
  - free_req = 1 for exactly the cycle after an s-side handshake with s_rlast=1. It is registered, along with a registered copy of the UID.
  - free_unique_id in that cycle carries the registered UID, overriding the s_rid passthrough.
  - Slave beats are stalled (s_rready=0) in any free_req cycle. This prevents the lookup from being redirected mid-free.
  - The tag for the freed slot is already captured in the buffer, so a later free cannot corrupt it.
- Ack tracking:
  - ack_pending is set with free_req and cleared by free_ack.
  - free_ack while ack_pending=0 sets err_ack.
  - ack_pending=1 for a second consecutive cycle without free_ack sets err_ack.
- Burst FSM:
  - IDLE --accepted beat, rlast=0--> BURST, locking lock_uid=s_rid.
  - IDLE --accepted beat, rlast=1--> IDLE (single-beat burst).
  - BURST --accepted beat, rlast=1--> IDLE.
  - In BURST, an accepted beat with s_rid != lock_uid sets err_interleave. The beat is still forwarded and the lock is unchanged.
- Ordering: per-original-ID response order is guaranteed by the issue side. This block does not reorder.
- Error flags are sticky until rst.
- Reset mid-burst or mid-skid drops all buffered beats. No free_req is emitted for them.
- Simultaneous events:
  - Skid push and pop in the same cycle keep occupancy unchanged.
  - A free_req cycle coinciding with m_rready=1 still drains the buffer.

Decomposition:
- Shared package axi_idmap_pkg:
  - AXI RRESP constants (OKAY/EXOKAY/SLVERR/DECERR).
  - uid_w() function.
  - Packed r_beat_t {id, data, resp, last}, parameterised through the package's widths.
  - The same package is reused by the allocator wrapper.
- Sub-module skid_buffer_2 (generic, WIDTH parameter, valid/ready both sides). It is instantiated once with WIDTH = $bits(r_beat_t).

Test Plan:
- Allocator model maps uid 0x5 -> id 0x3. Single beat s_rid=0x5, rlast=1, m_rready=1 -> m_rvalid next cycle with m_rid=0x3; free_req pulse, free_unique_id=0x5; next cycle free_ack, err_ack stays 0.
- 4-beat burst uid 0x9 -> id 0xA, m_rready=1 throughout -> 4 consecutive m beats with m_rid=0xA, m_rlast on beat 4 only; exactly one free_req.
- m_rready=0 for 5 cycles while slave streams -> two beats buffered, s_rready=0 from the third cycle, m_* stable; release -> data in order, none lost or duplicated.
- Burst uid 0x1 in progress, then a beat with uid 0x2 -> err_interleave=1 and sticky; the beat is forwarded with the restored ID.
- free_ack injected with nothing pending -> err_ack=1. Separately, free_ack withheld after free_req -> err_ack=1 two cycles later.
- rst asserted with 2 beats buffered mid-burst -> next cycle m_rvalid=0, FSM IDLE, no free_req, s_rready=1.

Source files
------------

// File: rtl/axi_idmap_pkg.sv
// ============================================================================
// Package : axi_idmap_pkg
// Shared AXI ID-remap types and constants for the R-side restore block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_idmap_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int uid_w(input int rows, input int cols);
    return $clog2(rows) + $clog2(cols);
  endfunction

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_beat_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

endpackage

`default_nettype wire

// File: rtl/skid_buffer_2.sv
// ============================================================================
// Module : skid_buffer_2
// Two-entry registered skid buffer; input ready comes straight from a flop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module skid_buffer_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             push;

  assign in_ready  = ~skid_valid_q;
  assign push      = in_valid & ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the skid entry (older) has priority over input.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_r_id_restore.sv
// ============================================================================
// Module : axi_r_id_restore
// Restores original ARIDs on R beats and frees allocator slots on last beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_r_id_restore
  import axi_idmap_pkg::*;
#(
  parameter  int ID_WIDTH   = 4,
  parameter  int NUM_ROWS   = 4,
  parameter  int NUM_COLS   = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int UID_W      = uid_w(NUM_ROWS, NUM_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [UID_W-1:0]      s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic                  free_req,
  output logic [UID_W-1:0]      free_unique_id,
  input  logic [ID_WIDTH-1:0]   restored_id,
  input  logic                  free_ack,
  output logic                  err_interleave,
  output logic                  err_ack
);

  logic             sb_in_ready;
  logic             s_hs;
  r_beat_t          beat_in;
  r_beat_t          beat_out;

  logic             free_req_q, free_req_d;
  logic [UID_W-1:0] free_uid_q, free_uid_d;
  logic             ack_pending_q, ack_pending_d;
  logic             err_ack_q, err_ack_d;
  logic             err_il_q, err_il_d;
  burst_state_e     state_q, state_d;
  logic [UID_W-1:0] lock_uid_q, lock_uid_d;

  // Stalling during the free cycle keeps the lookup pointed at s_rid only.
  assign s_rready = sb_in_ready & ~free_req_q;
  assign s_hs     = s_rvalid & s_rready;

  assign beat_in.id   = restored_id;
  assign beat_in.data = s_rdata;
  assign beat_in.resp = s_rresp;
  assign beat_in.last = s_rlast;

  skid_buffer_2 #(
    .WIDTH ($bits(r_beat_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_rvalid & ~free_req_q),
    .in_ready  (sb_in_ready),
    .in_data   (beat_in),
    .out_valid (m_rvalid),
    .out_ready (m_rready),
    .out_data  (beat_out)
  );

  assign m_rid   = beat_out.id;
  assign m_rdata = beat_out.data;
  assign m_rresp = beat_out.resp;
  assign m_rlast = beat_out.last;

  assign free_req       = free_req_q;
  assign free_unique_id = free_req_q ? free_uid_q : s_rid;
  assign err_interleave = err_il_q;
  assign err_ack        = err_ack_q;

  always_comb begin
    free_req_d    = s_hs & s_rlast;
    free_uid_d    = (s_hs & s_rlast) ? s_rid : free_uid_q;
    ack_pending_d = ack_pending_q;
    err_ack_d     = err_ack_q;
    if (free_ack) begin
      if (!ack_pending_q) err_ack_d = 1'b1;
      ack_pending_d = 1'b0;
    end else if (ack_pending_q && !free_req_q) begin
      // Pending for a second cycle with no acknowledge.
      err_ack_d     = 1'b1;
      ack_pending_d = 1'b0;
    end
    if (s_hs && s_rlast) ack_pending_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    lock_uid_d = lock_uid_q;
    err_il_d   = err_il_q;
    if (s_hs) begin
      case (state_q)
        ST_IDLE: begin
          if (!s_rlast) begin
            state_d    = ST_BURST;
            lock_uid_d = s_rid;
          end
        end
        ST_BURST: begin
          if (s_rid != lock_uid_q) err_il_d = 1'b1;
          if (s_rlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_req_q    <= 1'b0;
      free_uid_q    <= '0;
      ack_pending_q <= 1'b0;
      err_ack_q     <= 1'b0;
      err_il_q      <= 1'b0;
      state_q       <= ST_IDLE;
      lock_uid_q    <= '0;
    end else begin
      free_req_q    <= free_req_d;
      free_uid_q    <= free_uid_d;
      ack_pending_q <= ack_pending_d;
      err_ack_q     <= err_ack_d;
      err_il_q      <= err_il_d;
      state_q       <= state_d;
      lock_uid_q    <= lock_uid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_r_id_restore.sv
// ============================================================================
// Module : tb_axi_r_id_restore
// Directed self-checking bench for axi_r_id_restore with a small allocator model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_r_id_restore;

  localparam int UID_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_rvalid;
  logic        s_rready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        free_req;
  logic [3:0]  free_unique_id;
  logic [3:0]  restored_id;
  logic        free_ack;
  logic        err_interleave;
  logic        err_ack;

  int   total = 0;
  int   bad = 0;
  int   fr_count = 0;
  int   fr_base = 0;
  logic fr_prev = 1'b0;
  logic auto_ack = 1'b1;

  always #5 clk = ~clk;

  axi_r_id_restore #(
    .ID_WIDTH   (4),
    .NUM_ROWS   (4),
    .NUM_COLS   (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_rvalid       (s_rvalid),
    .s_rready       (s_rready),
    .s_rid          (s_rid),
    .s_rdata        (s_rdata),
    .s_rresp        (s_rresp),
    .s_rlast        (s_rlast),
    .m_rvalid       (m_rvalid),
    .m_rready       (m_rready),
    .m_rid          (m_rid),
    .m_rdata        (m_rdata),
    .m_rresp        (m_rresp),
    .m_rlast        (m_rlast),
    .free_req       (free_req),
    .free_unique_id (free_unique_id),
    .restored_id    (restored_id),
    .free_ack       (free_ack),
    .err_interleave (err_interleave),
    .err_ack        (err_ack)
  );

  function automatic logic [3:0] alloc_map(input logic [3:0] u);
    case (u)
      4'h5:    return 4'h3;
      4'h9:    return 4'hA;
      4'h1:    return 4'h6;
      4'h2:    return 4'h7;
      default: return 4'h0;
    endcase
  endfunction

  always_comb restored_id = alloc_map(free_unique_id);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic [3:0] id, input logic [31:0] data,
                       input logic last);
    chk({tag, "_valid"}, {31'd0, m_rvalid}, 32'd1);
    chk({tag, "_id"},    {28'd0, m_rid},    {28'd0, id});
    chk({tag, "_data"},  m_rdata,           data);
    chk({tag, "_last"},  {31'd0, m_rlast},  {31'd0, last});
  endtask

  // Advance one cycle; the allocator model acks the cycle after each free_req.
  task automatic step();
    @(posedge clk);
    #1;
    if (free_req === 1'b1) fr_count++;
    free_ack = auto_ack & fr_prev;
    fr_prev  = free_req;
  endtask

  task automatic drive(input logic v, input logic [3:0] uid, input logic [31:0] data,
                       input logic last);
    s_rvalid = v;
    s_rid    = uid;
    s_rdata  = data;
    s_rlast  = last;
  endtask

  initial begin
    rst = 1'b1; m_rready = 1'b1; free_ack = 1'b0; s_rresp = 2'b00;
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step(); step();

    chk("rst_m_rvalid", {31'd0, m_rvalid}, 32'd0);
    chk("rst_free_req", {31'd0, free_req}, 32'd0);
    chk("rst_err_il",   {31'd0, err_interleave}, 32'd0);
    chk("rst_err_ack",  {31'd0, err_ack}, 32'd0);
    chk("rst_m_rid",    {28'd0, m_rid}, 32'd0);
    chk("rst_m_rdata",  m_rdata, 32'd0);
    chk("rst_m_rlast",  {31'd0, m_rlast}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_s_rready", {31'd0, s_rready}, 32'd1);

    // Single-beat burst uid 5 -> id 3
    drive(1'b1, 4'h5, 32'h1111_0001, 1'b1);
    #1;
    chk("t1_lookup", {28'd0, free_unique_id}, 32'h5);
    step();
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    #1;
    chk_m("t1", 4'h3, 32'h1111_0001, 1'b1);
    chk("t1_free_req", {31'd0, free_req}, 32'd1);
    chk("t1_free_uid", {28'd0, free_unique_id}, 32'h5);
    chk("t1_stall",    {31'd0, s_rready}, 32'd0);
    step();
    chk("t1_drain",    {31'd0, m_rvalid}, 32'd0);
    chk("t1_free_end", {31'd0, free_req}, 32'd0);
    step();
    chk("t1_err_ack",  {31'd0, err_ack}, 32'd0);

    // Four-beat burst uid 9 -> id A at full rate
    fr_base = fr_count;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_s_rready%0d", i), {31'd0, s_rready}, 32'd1);
      drive(1'b1, 4'h9, 32'hB000_0000 + 32'(i), (i == 3));
      step();
      chk_m($sformatf("t2_beat%0d", i), 4'hA, 32'hB000_0000 + 32'(i), (i == 3));
    end
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    chk("t2_drain", {31'd0, m_rvalid}, 32'd0);
    step(); step();
    chk("t2_one_free", 32'(fr_count - fr_base), 32'd1);
    chk("t2_err_ack",  {31'd0, err_ack}, 32'd0);

    // Backpressure: m_rready low for five cycles while the slave streams
    m_rready = 1'b0;
    drive(1'b1, 4'h5, 32'hE000_0000, 1'b0);
    step();
    chk_m("t3_c1", 4'h3, 32'hE000_0000, 1'b0);
    chk("t3_c1_rdy", {31'd0, s_rready}, 32'd1);
    drive(1'b1, 4'h5, 32'hE000_0001, 1'b0);
    step();
    chk("t3_c2_rdy", {31'd0, s_rready}, 32'd0);
    chk_m("t3_c2", 4'h3, 32'hE000_0000, 1'b0);
    drive(1'b1, 4'h5, 32'hE000_0002, 1'b1);
    step();
    chk("t3_c3_rdy", {31'd0, s_rready}, 32'd0);
    chk_m("t3_c3", 4'h3, 32'hE000_0000, 1'b0);
    step();
    chk_m("t3_c4", 4'h3, 32'hE000_0000, 1'b0);
    step();
    chk_m("t3_c5", 4'h3, 32'hE000_0000, 1'b0);
    chk("t3_c5_rdy", {31'd0, s_rready}, 32'd0);
    m_rready = 1'b1;
    step();
    chk_m("t3_c6", 4'h3, 32'hE000_0001, 1'b0);
    chk("t3_c6_rdy", {31'd0, s_rready}, 32'd1);
    step();
    chk_m("t3_c7", 4'h3, 32'hE000_0002, 1'b1);
    chk("t3_free", {31'd0, free_req}, 32'd1);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    chk("t3_no_dup", {31'd0, m_rvalid}, 32'd0);
    chk("t3_no_il",  {31'd0, err_interleave}, 32'd0);

    // Interleave: burst on uid 1, foreign beat on uid 2
    step();
    drive(1'b1, 4'h1, 32'hF000_0000, 1'b0);
    step();
    chk_m("t4_f0", 4'h6, 32'hF000_0000, 1'b0);
    chk("t4_il_clear", {31'd0, err_interleave}, 32'd0);
    drive(1'b1, 4'h2, 32'hF000_0001, 1'b0);
    step();
    chk_m("t4_f1", 4'h7, 32'hF000_0001, 1'b0);
    chk("t4_il_set", {31'd0, err_interleave}, 32'd1);
    drive(1'b1, 4'h1, 32'hF000_0002, 1'b1);
    step();
    chk_m("t4_f2", 4'h6, 32'hF000_0002, 1'b1);
    chk("t4_free", {31'd0, free_req}, 32'd1);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step(); step();
    chk("t4_il_sticky", {31'd0, err_interleave}, 32'd1);

    // Unexpected free_ack
    step();
    chk("t5a_pre", {31'd0, err_ack}, 32'd0);
    auto_ack = 1'b0;
    free_ack = 1'b1;
    step();
    chk("t5a_err_ack", {31'd0, err_ack}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_err_ack", {31'd0, err_ack}, 32'd0);
    chk("t5_rst_err_il",  {31'd0, err_interleave}, 32'd0);

    // Withheld free_ack
    drive(1'b1, 4'h9, 32'hC000_0000, 1'b1);
    step();
    chk("t5b_free", {31'd0, free_req}, 32'd1);
    chk("t5b_c1",   {31'd0, err_ack}, 32'd0);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    chk("t5b_c2",   {31'd0, err_ack}, 32'd0);
    step();
    chk("t5b_c3",   {31'd0, err_ack}, 32'd1);

    // Reset with two beats buffered mid-burst
    auto_ack = 1'b1;
    m_rready = 1'b0;
    drive(1'b1, 4'h5, 32'h6000_0000, 1'b0);
    step();
    drive(1'b1, 4'h5, 32'h6000_0001, 1'b0);
    step();
    chk("t6_full_rdy", {31'd0, s_rready}, 32'd0);
    chk("t6_full_vld", {31'd0, m_rvalid}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    chk("t6_m_rvalid", {31'd0, m_rvalid}, 32'd0);
    chk("t6_s_rready", {31'd0, s_rready}, 32'd1);
    chk("t6_free_req", {31'd0, free_req}, 32'd0);
    chk("t6_err_ack",  {31'd0, err_ack}, 32'd0);
    chk("t6_m_rdata",  m_rdata, 32'd0);
    rst = 1'b0;
    m_rready = 1'b1;
    fr_base = fr_count;
    step(); step();
    chk("t6_no_free", 32'(fr_count - fr_base), 32'd0);
    drive(1'b1, 4'h2, 32'h7000_0000, 1'b0);
    step();
    chk_m("t6_h0", 4'h7, 32'h7000_0000, 1'b0);
    drive(1'b1, 4'h2, 32'h7000_0001, 1'b1);
    step();
    chk_m("t6_h1", 4'h7, 32'h7000_0001, 1'b1);
    chk("t6_h1_free", {31'd0, free_req}, 32'd1);
    chk("t6_idle_il", {31'd0, err_interleave}, 32'd0);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step(); step();
    chk("t6_ack_ok", {31'd0, err_ack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
